// File: rtl/ru_seq_ctrl_if.sv
// Request/result handshake bundle between the function-request front end and ru_seq_ctrl.
// The front end is the master; the sequencer is the slave.
interface ru_seq_ctrl_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_x;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic [W-1:0] out_aux;

  modport master (
    output in_valid, in_op, in_x, out_ready,
    input  in_ready, out_valid, out_res, out_aux
  );

  modport slave (
    input  in_valid, in_op, in_x, out_ready,
    output in_ready, out_valid, out_res, out_aux
  );
endinterface

// File: rtl/ru_seq_ctrl.sv
// Steps one combinational ru instance through a fixed per-op schedule of {s_mux, s_mult},
// feeding each step's outputs back as the next step's inputs.
module ru_seq_ctrl #(
  parameter int FIX_POINT_WIDTH = 16,
  parameter int Bf              = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  ru_seq_ctrl_if.slave               bus,
  output logic                       busy_o,
  output logic [FIX_POINT_WIDTH-1:0] ru_in0_o,
  output logic [FIX_POINT_WIDTH-1:0] ru_in1_o,
  output logic                       ru_s_mux_o,
  output logic [2:0]                 ru_s_mult_o,
  input  logic [FIX_POINT_WIDTH-1:0] ru_out0_i,
  input  logic [FIX_POINT_WIDTH-1:0] ru_out1_i
);

  localparam int W = FIX_POINT_WIDTH;

  // Bf only has to be consistent with the ru instance; no arithmetic depends on it here.
  if (Bf < 0 || Bf >= W) begin : g_bad_bf
    $error("ru_seq_ctrl: Bf must lie in [0, FIX_POINT_WIDTH)");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [1:0]     op_q;
  logic [1:0]     step_q;
  logic [W-1:0]   a0_q;
  logic [W-1:0]   a1_q;
  logic [3:0]     sel;

  // Schedule ROM, {s_mux, s_mult}; op N runs N+1 steps so its last step index equals op.
  function automatic logic [3:0] schedSel(input logic [1:0] op, input logic [1:0] step);
    logic [3:0] s;
    s = 4'd0;
    case (op)
      2'd0: s = 4'b0_000;
      2'd1: s = (step == 2'd0) ? 4'b0_001 : 4'b1_001;
      2'd2: begin
        case (step)
          2'd0:    s = 4'b0_010;
          2'd1:    s = 4'b1_011;
          default: s = 4'b1_100;
        endcase
      end
      default: begin
        case (step)
          2'd0:    s = 4'b0_101;
          2'd1:    s = 4'b1_110;
          2'd2:    s = 4'b1_110;
          default: s = 4'b1_111;
        endcase
      end
    endcase
    return s;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      step_q  <= 2'd0;
      a0_q    <= '0;
      a1_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q    <= bus.in_op;
            step_q  <= 2'd0;
            a0_q    <= bus.in_x;
            a1_q    <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a0_q <= ru_out0_i;
          a1_q <= ru_out1_i;
          if (step_q == op_q) begin
            state_q <= DONE;
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Everything below decodes straight from registered state, so ru sees stable inputs all cycle.
  assign sel           = (state_q == RUN) ? schedSel(op_q, step_q) : 4'd0;
  assign ru_in0_o      = (state_q == RUN) ? a0_q : '0;
  assign ru_in1_o      = (state_q == RUN) ? a1_q : '0;
  assign ru_s_mux_o    = sel[3];
  assign ru_s_mult_o   = sel[2:0];

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_res   = (state_q == DONE) ? a0_q : '0;
  assign bus.out_aux   = (state_q == DONE) ? a1_q : '0;
  assign busy_o        = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_ru_seq_ctrl.sv
// Self-checking bench for ru_seq_ctrl with a stub ru (out0 = in0 + {s_mux,s_mult}, out1 = in0 ^ in1);
// expected results come from a behavioural schedule-walk model.
module tb_ru_seq_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         busy;
  logic [W-1:0] ruIn0;
  logic [W-1:0] ruIn1;
  logic         ruSMux;
  logic [2:0]   ruSMult;
  logic [W-1:0] ruOut0;
  logic [W-1:0] ruOut1;

  int checks = 0;
  int errors = 0;

  // Per-op schedule as {s_mux, s_mult} values; op N has N+1 meaningful entries.
  int sched [4][4] = '{'{0, 0, 0, 0}, '{1, 9, 0, 0}, '{2, 11, 12, 0}, '{5, 14, 14, 15}};

  ru_seq_ctrl_if #(.W(W)) bus ();

  ru_seq_ctrl #(.FIX_POINT_WIDTH(W), .Bf(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .busy_o      (busy),
    .ru_in0_o    (ruIn0),
    .ru_in1_o    (ruIn1),
    .ru_s_mux_o  (ruSMux),
    .ru_s_mult_o (ruSMult),
    .ru_out0_i   (ruOut0),
    .ru_out1_i   (ruOut1)
  );

  assign ruOut0 = ruIn0 + {12'd0, ruSMux, ruSMult};
  assign ruOut1 = ruIn0 ^ ruIn1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void refModel(input logic [1:0] op, input logic [W-1:0] x,
                                   output logic [W-1:0] res, output logic [W-1:0] aux);
    logic [W-1:0] v0, v1, n0;
    v0 = x;
    v1 = '0;
    for (int k = 0; k <= int'(op); k++) begin
      n0 = v0 + W'(sched[op][k]);
      v1 = v0 ^ v1;
      v0 = n0;
    end
    res = v0;
    aux = v1;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_res_aux"}, {bus.out_res, bus.out_aux}, 32'd0);
    checkOutput({tag, "_ru_bus"}, {ruIn0, ruIn1}, 32'd0);
    checkOutput({tag, "_ru_sel"}, {28'd0, ruSMux, ruSMult}, 32'd0);
  endtask

  // Called just after a negedge with the DUT idle; returns just after the negedge following consume.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] x, input int holdCycles,
                               input bit junkValid, input bit earlyReady);
    logic [W-1:0] expRes, expAux;
    int cycles;
    int step;
    refModel(op, x, expRes, expAux);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_x     = x;
    checkOutput("accept_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    if (junkValid) begin
      bus.in_op = 2'($urandom_range(0, 3));
      bus.in_x  = ~x;
    end else begin
      bus.in_valid = 1'b0;
    end
    bus.out_ready = earlyReady;
    cycles = 1;
    while (!bus.out_valid && cycles < 20) begin
      step = cycles - 1;
      checkOutput("run_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("run_busy", 32'(busy), 32'd1);
      if (step <= int'(op)) begin
        checkOutput("run_sel", {28'd0, ruSMux, ruSMult}, 32'(sched[op][step]));
      end else begin
        checkOutput("run_too_long", 32'(step), 32'(op));
      end
      @(negedge clk);
      cycles++;
    end
    if (!bus.out_valid) begin
      checkOutput("timeout_out_valid", 32'(bus.out_valid), 32'd1);
    end
    checkOutput("latency", 32'(cycles), 32'(int'(op) + 2));
    checkOutput("done_res", 32'(bus.out_res), 32'(expRes));
    checkOutput("done_aux", 32'(bus.out_aux), 32'(expAux));
    checkOutput("done_busy", 32'(busy), 32'd1);
    checkOutput("done_ru_idle", {ruIn0, ruIn1}, 32'd0);
    bus.out_ready = 1'b0;
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("hold_res_aux", {bus.out_res, bus.out_aux}, {expRes, expAux});
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkIdle("consumed");
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] rx;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_x      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed sequences");
    applyStimulus(2'd0, 16'h0400, 0, 1'b0, 1'b1);
    applyStimulus(2'd3, 16'h0010, 0, 1'b0, 1'b0);
    applyStimulus(2'd1, 16'h0100, 6, 1'b0, 1'b0);
    applyStimulus(2'd2, 16'h0123, 2, 1'b1, 1'b0);

    // Reset lands while op2 is on its second step; the in-flight result must vanish.
    bus.in_valid = 1'b1;
    bus.in_op    = 2'd2;
    bus.in_x     = 16'h0777;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrun_sel", {28'd0, ruSMux, ruSMult}, 32'(sched[2][1]));
    rst = 1'b1;
    @(negedge clk);
    checkIdle("midrun_reset");
    rst = 1'b0;
    applyStimulus(2'd0, 16'h1234, 0, 1'b0, 1'b0);

    applyStimulus(2'd0, 16'h0001, 0, 1'b0, 1'b0);
    applyStimulus(2'd0, 16'hFFFF, 0, 1'b0, 1'b0);

    $display("[TB] randomized sequences");
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      rx  = 16'($urandom);
      applyStimulus(rop, rx, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
